block_input: RTL and testbench

BLOCK_INPUT -- requirements
Module: block_input

---
 rtl/block_input.sv | 108 ++++++++++
 tb/tb_block_input.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/block_input.sv
// Router input buffer: show-ahead circular FIFO with registered near-full (ret) flow control.
// Optional sticky overflow flag built only when BLOCK_INPUT_OVF_CHK_EN is defined.
module block_input #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        Data_in,
    input  logic                         val,
    output logic                         ret,
    input  logic                         read,
    output logic [DATA_WIDTH-1:0]        Data_out,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HI_CNT   = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LO_CNT   = CW'(DEPTH - 2);

    typedef enum logic {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } fc_state_t;

    fc_state_t               state, state_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count_q, count_nxt;
    logic                    rd_acc, wr_acc;

    // A read frees a slot in the same edge, so a full buffer still accepts a write alongside it.
    assign rd_acc = read && (count_q != '0);
    assign wr_acc = val && ((count_q < FULL_CNT) || rd_acc);

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count_q <= count_nxt;
            if (wr_acc) begin
                mem[wr_ptr] <= Data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Flow control looks at next occupancy so ret rises one slot early for the in-flight flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCEPT:  if (count_nxt >= HI_CNT) state_nxt = HOLD;
            HOLD:    if (count_nxt <= LO_CNT) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    assign ret      = (state == HOLD);
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign Data_out = mem[rd_ptr];

`ifdef BLOCK_INPUT_OVF_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (val && !wr_acc) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_block_input.sv
// Randomized bench for block_input against a queue-based occupancy/order model.
`timescale 1ns/1ps
module tb_block_input;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          val = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] Data_in = '0;
    logic [DW-1:0] Data_out;
    logic          ret, empty, err;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned q[$];
    bit           ret_m = 1'b0;
    bit           err_m = 1'b0;
    bit           last_rd, last_wr;
    byte unsigned last_pop;

    always #5 clk = ~clk;

    block_input #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .Data_in  (Data_in),
        .val      (val),
        .ret      (ret),
        .read     (read),
        .Data_out (Data_out),
        .empty    (empty),
        .count    (count),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".ret"},   32'(ret),   32'(ret_m));
        check({tag, ".err"},   32'(err),   32'(err_m));
        if (q.size() > 0) check({tag, ".dout"}, 32'(Data_out), 32'(q[0]));
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        bit rd, wr;
        val = v; Data_in = d; read = r;
        @(posedge clk);
        rd = r && (q.size() > 0);
        wr = v && ((q.size() < DEPTH) || rd);
        if (rd) last_pop = q.pop_front();
        if (wr) q.push_back(d);
`ifdef BLOCK_INPUT_OVF_CHK_EN
        if (v && !wr) err_m = 1'b1;
`endif
        if (q.size() >= DEPTH - 1) ret_m = 1'b1;
        else if (q.size() <= DEPTH - 2) ret_m = 1'b0;
        last_rd = rd; last_wr = wr;
        #1;
        check_state("step");
    endtask

    // Asserts reset between edges, checks outputs with no edge, then releases it.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        q.delete(); ret_m = 1'b0; err_m = 1'b0;
        check({tag, ".count"}, 32'(count),    32'd0);
        check({tag, ".empty"}, 32'(empty),    32'd1);
        check({tag, ".ret"},   32'(ret),      32'd0);
        check({tag, ".dout"},  32'(Data_out), 32'd0);
        check({tag, ".err"},   32'(err),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0]   exp_list [4];
        byte unsigned got[$];
        int           next, cyc;
        bit           v, r;
        logic [31:0]  ovf_err;

`ifdef BLOCK_INPUT_OVF_CHK_EN
        ovf_err = 32'd1;
`else
        ovf_err = 32'd0;
`endif

        // Power-on reset
        #1 rst = 1'b0;
        #2;
        check("por.count", 32'(count), 32'd0);
        check("por.empty", 32'(empty), 32'd1);
        check("por.ret",   32'(ret),   32'd0);
        check("por.dout",  32'(Data_out), 32'd0);
        check("por.err",   32'(err),   32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset mid-stream with two flits buffered
        step(1, 8'hA1, 0);
        step(1, 8'hA2, 0);
        check("mid.count_before", 32'(count), 32'd2);
        do_reset("midrst");

        // Fill, overflow, full read+write, drain
        step(1, 8'h11, 0);
        step(1, 8'h12, 0);
        check("fill.ret2", 32'(ret), 32'd0);
        step(1, 8'h13, 0);
        check("fill.ret3", 32'(ret), 32'd1);
        step(1, 8'h14, 0);
        check("fill.count4", 32'(count), 32'd4);
        check("fill.dout",   32'(Data_out), 32'h11);

        step(1, 8'h15, 0);
        check("ovf.count", 32'(count), 32'd4);
        check("ovf.dout",  32'(Data_out), 32'h11);
        check("ovf.err",   32'(err), ovf_err);

        step(1, 8'h15, 1);
        check("frw.count", 32'(count), 32'd4);
        check("frw.dout",  32'(Data_out), 32'h12);
        check("frw.ret",   32'(ret), 32'd1);
        check("frw.err_sticky", 32'(err), ovf_err);

        exp_list = '{8'h12, 8'h13, 8'h14, 8'h15};
        for (int i = 0; i < 4; i++) begin
            check("drain1.dout", 32'(Data_out), 32'(exp_list[i]));
            step(0, 8'h00, 1);
        end
        check("drain1.empty", 32'(empty), 32'd1);

        // Fill 0x11..0x14 then drain in order
        do_reset("rst2");
        for (int i = 0; i < 4; i++) step(1, 8'(8'h11 + i), 0);
        for (int i = 0; i < 4; i++) begin
            check("drain2.dout", 32'(Data_out), 32'(8'h11 + i));
            step(0, 8'h00, 1);
            if (i == 1) begin
                check("drain2.count2", 32'(count), 32'd2);
                check("drain2.ret_low", 32'(ret), 32'd0);
            end
        end
        check("drain2.empty", 32'(empty), 32'd1);
        step(0, 8'h00, 1);
        check("drain2.read_empty", 32'(count), 32'd0);

        // Wrap: 12 sequential flits under random val/read mix
        do_reset("rst3");
        next = 0; cyc = 0;
        while ((next < 12 || q.size() > 0) && cyc < 400) begin
            v = (next < 12) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) == 1);
            step(v, 8'(next), r);
            if (last_wr) next++;
            if (last_rd) got.push_back(last_pop);
            check("wrap.count_max", 32'(count <= 4), 32'd1);
            cyc++;
        end
        check("wrap.bound", 32'(cyc < 400), 32'd1);
        check("wrap.n_out", 32'(got.size()), 32'd12);
        for (int i = 0; i < got.size(); i++) check("wrap.order", 32'(got[i]), 32'(i));

        // Random traffic with phases biased toward full and toward empty
        do_reset("rst4");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rndrst");
            end else if ((i / 50) % 2 == 0) begin
                step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);
            end else begin
                step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
